// File: rtl/prefix_sub8_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : prefix_sub8_pipe_if
// Brief    : Operand/result handshake bundle for the 8-bit pipelined subtractor.
// Revision : 1.0
// ============================================================================
interface prefix_sub8_pipe_if;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
    logic       zero;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output a, b, bin, in_valid, out_ready,
        input  in_ready, diff, bout, ovf, zero, out_valid
    );

    modport slave (
        input  a, b, bin, in_valid, out_ready,
        output in_ready, diff, bout, ovf, zero, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/prefix_sub8_pipe.sv
`default_nettype none
// ============================================================================
// Module   : prefix_sub8_pipe
// Brief    : 3-stage a - b - bin subtractor with a Kogge-Stone carry network.
// Revision : 1.0
// ============================================================================
module prefix_sub8_pipe (
    input  wire logic          clk,
    input  wire logic          rst,
    prefix_sub8_pipe_if.slave  s_bus
);
    logic       r_v1, r_v2, r_v3;
    logic [7:0] r1_a, r1_nb, r1_p, r1_g;
    logic       r1_nbin;
    logic [7:0] r2_x, r2_g;
    logic [7:4] r2_p;
    logic       r2_nbin, r2_a7, r2_b7;
    logic [7:0] r_diff;
    logic       r_bout, r_ovf, r_zero;

    logic       w_advance;
    logic [7:0] w_nb;
    logic [7:0] w_g0, w_g1, w_g2, w_g3;
    logic [7:2] w_p1;
    logic [7:4] w_p2;
    logic [7:0] w_c, w_sum;

    // rst forces the stall path open so the block looks idle and ready during reset.
    assign w_advance = ~r_v3 | s_bus.out_ready | rst;
    assign w_nb      = ~s_bus.b;

    // Borrow-in enters as carry-in folded into bit 0's generate term.
    assign w_g0[0]   = r1_g[0] | (r1_p[0] & r1_nbin);
    assign w_g0[7:1] = r1_g[7:1];

    generate
        for (genvar i = 0; i < 8; i++) begin : g_lvl1
            if (i >= 1) begin : g_cmb
                assign w_g1[i] = w_g0[i] | (r1_p[i] & w_g0[i-1]);
            end else begin : g_pass
                assign w_g1[i] = w_g0[i];
            end
            if (i >= 2) begin : g_prop
                assign w_p1[i] = r1_p[i] & r1_p[i-1];
            end
        end

        for (genvar i = 0; i < 8; i++) begin : g_lvl2
            if (i >= 2) begin : g_cmb
                assign w_g2[i] = w_g1[i] | (w_p1[i] & w_g1[i-2]);
            end else begin : g_pass
                assign w_g2[i] = w_g1[i];
            end
            if (i >= 4) begin : g_prop
                assign w_p2[i] = w_p1[i] & w_p1[i-2];
            end
        end

        for (genvar i = 0; i < 8; i++) begin : g_lvl3
            if (i >= 4) begin : g_cmb
                assign w_g3[i] = r2_g[i] | (r2_p[i] & r2_g[i-4]);
            end else begin : g_pass
                assign w_g3[i] = r2_g[i];
            end
        end
    endgenerate

    assign w_c   = {w_g3[6:0], r2_nbin};
    assign w_sum = r2_x ^ w_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r1_a    <= 8'h00;
            r1_nb   <= 8'h00;
            r1_p    <= 8'h00;
            r1_g    <= 8'h00;
            r1_nbin <= 1'b0;
            r2_x    <= 8'h00;
            r2_g    <= 8'h00;
            r2_p    <= 4'h0;
            r2_nbin <= 1'b0;
            r2_a7   <= 1'b0;
            r2_b7   <= 1'b0;
            r_diff  <= 8'h00;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_advance) begin
            r_v1    <= s_bus.in_valid;
            r_v2    <= r_v1;
            r_v3    <= r_v2;

            r1_a    <= s_bus.a;
            r1_nb   <= w_nb;
            r1_p    <= s_bus.a | w_nb;
            r1_g    <= s_bus.a & w_nb;
            r1_nbin <= ~s_bus.bin;

            r2_x    <= r1_a ^ r1_nb;
            r2_g    <= w_g2;
            r2_p    <= w_p2;
            r2_nbin <= r1_nbin;
            r2_a7   <= r1_a[7];
            r2_b7   <= ~r1_nb[7];

            r_diff  <= w_sum;
            r_bout  <= ~w_g3[7];
            r_ovf   <= (r2_a7 != r2_b7) & (w_sum[7] != r2_a7);
            r_zero  <= (w_sum == 8'h00);
        end
    end

    assign s_bus.in_ready  = w_advance;
    assign s_bus.out_valid = r_v3 & ~rst;
    assign s_bus.diff      = r_diff;
    assign s_bus.bout      = r_bout;
    assign s_bus.ovf       = r_ovf;
    assign s_bus.zero      = r_zero;
endmodule
`default_nettype wire

// File: doc/prefix_sub8_pipe.md
PREFIX_SUB8_PIPE -- requirements
Module: prefix_sub8_pipe

Interface
REQ-001 SHALL have no parameters; operand width is fixed at 8 bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  reset, synchronous to clk and active-high.
REQ-004 SHALL have port a  input  8  minuend, unsigned or two's complement.
REQ-005 SHALL have port b  input  8  subtrahend.
REQ-006 SHALL have port bin  input  1  borrow-in; 1 subtracts one more.
REQ-007 SHALL have port in_valid  input  1  a/b/bin valid this cycle.
REQ-008 SHALL have port in_ready  output  1  block accepts an operand set this cycle.
REQ-009 SHALL have port diff  output  8  result (a - b - bin) mod 256.
REQ-010 SHALL have port bout  output  1  borrow-out; 1 iff a < b + bin, unsigned.
REQ-011 SHALL have port ovf  output  1  signed overflow of the subtraction.
REQ-012 SHALL have port zero  output  1  1 iff diff == 0x00.
REQ-013 SHALL have port out_valid  output  1  diff/bout/ovf/zero valid.
REQ-014 SHALL have port out_ready  input  1  consumer takes the result this cycle.

Function
REQ-015 SHALL compute the difference as a + ~b + ~bin, with carry-in ~bin, and bout = ~carry-out.
REQ-016 SHALL form per-bit propagate as OR and generate as AND of a[i] and ~b[i].
REQ-017 SHALL resolve carries with a 3-level log-depth prefix network of (p,g) combine cells: g = g1 | (p1 & g0), p = p1 & p0.
REQ-018 SHALL form each sum bit as a[i] ^ ~b[i] ^ c[i], where c[0] = ~bin.
REQ-019 SHALL be a 3-stage pipeline with the following stage contents.
 - S1: register a, ~b, ~bin and per-bit p/g.
 - S2: register prefix levels 1-2.
 - S3: register prefix level 3, diff and flags.
REQ-020 SHALL hold a valid bit v1/v2/v3 for each stage; out_valid = v3.
REQ-021 SHALL define advance = ~v3 | out_ready and in_ready = advance, combinationally.
REQ-022 SHALL accept a transfer only when in_valid & in_ready, and complete one only when out_valid & out_ready.
REQ-023 When advance = 1, all stages SHALL shift one position per cycle: v1 <= in_valid, v2 <= v1, v3 <= v2.
REQ-024 When advance = 0, all stage registers SHALL hold, and diff/bout/ovf/zero SHALL stay stable while out_valid = 1.
REQ-025 SHALL give latency of exactly 3 cycles from acceptance to out_valid when advance stays 1, with throughput of one result per cycle.
REQ-026 Bubbles (in_valid = 0 while advancing) SHALL propagate as invalid stages and SHALL NOT be collapsed.
REQ-027 SHALL set ovf = (a[7] != b[7]) & (diff[7] != a[7]).
REQ-028 SHALL present results in acceptance order, with no reordering, drops or duplicates.
REQ-029 SHALL ignore a, b and bin whenever in_ready = 0 or in_valid = 0.
REQ-030 Simultaneous output handoff and input acceptance in the same cycle SHALL both occur.

Reset
REQ-031 On a clk edge with rst = 1, v1, v2 and v3 SHALL clear to 0, and diff, bout, ovf and zero SHALL clear to 0.
REQ-032 While rst = 1, out_valid SHALL be 0 and in_ready SHALL be 1.
REQ-033 Reset mid-operation SHALL discard every in-flight operand set.
REQ-034 No result accepted before or during reset SHALL appear afterwards.

Verification
REQ-035 The bench SHALL cover a=0x05, b=0x03, bin=0 -> 3 cycles later diff=0x02, bout=0, ovf=0, zero=0.
REQ-036 The bench SHALL cover a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1, ovf=0, zero=0.
REQ-037 The bench SHALL cover a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1; and a=0x10, b=0x0F, bin=1 -> diff=0x00, zero=1, bout=0.
REQ-038 The bench SHALL cover back-to-back streaming of 0x00-0xFF minus 0x5A with out_ready=1 -> one result per cycle, each matching (a-0x5A) mod 256, in order.
REQ-039 The bench SHALL cover backpressure: fill 3 stages, hold out_ready=0 for 5 cycles -> in_ready=0, and out_valid=1 with diff constant throughout; then out_ready=1 -> the 3 results drain in order.
REQ-040 The bench SHALL cover reset: assert rst for 1 cycle with 2 items in flight -> next cycle out_valid=0, and no stale result ever emerges.
REQ-041 The bench SHALL cover random a/b/bin with random out_ready, checked against a reference model of a-b-bin for all outputs.
